// File: rtl/cpu_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_ctrl_pkg
// Description : Shared definitions for the CPU run/stop/step controller:
//               command opcodes, controller state encoding, default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_run_ctrl_pkg;

  // Default widths for the step counter and the free-running cycle counter
  localparam int CNT_W_DEF = 16;
  localparam int CYC_W_DEF = 32;

  // Host/debug command opcodes carried on cmd_op
  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_RUN  = 2'b01,
    OP_STOP = 2'b10,
    OP_STEP = 2'b11
  } cmd_op_e;

  // Controller states
  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUNNING  = 2'd1,
    STEPPING = 2'd2,
    STOPPING = 2'd3
  } run_state_e;

endpackage : cpu_run_ctrl_pkg
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_ctrl
// Description : Run/stop/single-step controller feeding the phaser run input.
//               Accepts RUN/STOP/STEP commands, counts completed CPU cycles
//               from release_cs, honours breakpoints and reports halted once
//               the phaser confirms it has stopped.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int CYC_W  = CYC_W_DEF,
  parameter bit BRK_EN = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             brk_hit,
  input  logic             ph_stopped,
  input  logic             ph_release_cs,
  output logic             ph_run,
  output logic             halted,
  output logic [CNT_W-1:0] steps_left,
  output logic             brk_flag,
  output logic [CYC_W-1:0] cycle_cnt
);

  run_state_e       state_q, state_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             brk_q, brk_d;
  logic             run_q;
  logic [CYC_W-1:0] cyc_q;

  cmd_op_e          op;
  logic             accept;
  logic             brk_take;
  logic             last_step;
  logic             count_nz;
  logic [CNT_W-1:0] steps_dec;

  assign op        = cmd_op_e'(cmd_op);
  assign cmd_ready = (state_q != STOPPING);
  assign accept    = cmd_valid && cmd_ready;
  assign brk_take  = BRK_EN && ph_release_cs && brk_hit;
  assign count_nz  = (cmd_count != '0);
  // Guarded decrement: steps_left never wraps below zero
  assign steps_dec = (ph_release_cs && (steps_q != '0)) ? steps_q - CNT_W'(1) : steps_q;
  assign last_step = ph_release_cs && (steps_q == CNT_W'(1));

  // Next-state logic: command decode, breakpoint priority and step counting
  always_comb begin
    state_d = state_q;
    steps_d = steps_q;
    brk_d   = brk_q;
    case (state_q)
      STOPPED: begin
        if (accept) begin
          if (op == OP_RUN) begin
            state_d = RUNNING;
            brk_d   = 1'b0;
          end else if ((op == OP_STEP) && count_nz) begin
            state_d = STEPPING;
            steps_d = cmd_count;
            brk_d   = 1'b0;
          end
        end
      end
      RUNNING: begin
        // A breakpoint wins over a same-cycle command; that command is dropped
        if (brk_take) begin
          state_d = STOPPING;
          brk_d   = 1'b1;
        end else if (accept) begin
          if (op == OP_STOP) begin
            state_d = STOPPING;
          end else if (op == OP_STEP) begin
            state_d = count_nz ? STEPPING : STOPPING;
            steps_d = cmd_count;
          end
        end
      end
      STEPPING: begin
        steps_d = steps_dec;
        if (brk_take) begin
          state_d = STOPPING;
          brk_d   = 1'b1;
        end else if (accept && (op == OP_STEP)) begin
          // A reload replaces any same-cycle decrement
          steps_d = cmd_count;
          state_d = count_nz ? STEPPING : STOPPING;
        end else if (accept && (op == OP_RUN)) begin
          state_d = RUNNING;
          steps_d = '0;
        end else if ((accept && (op == OP_STOP)) || last_step) begin
          state_d = STOPPING;
        end
      end
      STOPPING: begin
        if (ph_stopped) begin
          state_d = STOPPED;
        end
      end
      default: state_d = STOPPED;
    endcase
  end

  // State, counters and the registered phaser run request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= STOPPED;
      steps_q <= '0;
      brk_q   <= 1'b0;
      run_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      steps_q <= steps_d;
      brk_q   <= brk_d;
      run_q   <= (state_q == RUNNING) || (state_q == STEPPING);
      if (ph_release_cs) begin
        cyc_q <= cyc_q + CYC_W'(1);
      end
    end
  end

  assign ph_run     = run_q;
  assign steps_left = steps_q;
  assign brk_flag   = brk_q;
  assign cycle_cnt  = cyc_q;
  assign halted     = (state_q == STOPPED) && ph_stopped;

endmodule : cpu_run_ctrl
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_run_ctrl
// Description : Self-checking bench for cpu_run_ctrl with a small phaser
//               stand-in (6-clk CPU cycle, run sampled at each boundary) and
//               a behavioural reference model of the controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

  localparam int CNT_W = 16;
  localparam int CYC_W = 32;

  localparam logic [1:0] C_NOP  = 2'b00;
  localparam logic [1:0] C_RUN  = 2'b01;
  localparam logic [1:0] C_STOP = 2'b10;
  localparam logic [1:0] C_STEP = 2'b11;

  // Reference model modes
  localparam int M_IDLE  = 0;
  localparam int M_FREE  = 1;
  localparam int M_COUNT = 2;
  localparam int M_DRAIN = 3;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             brk_hit = 1'b0;
  logic             ph_stopped;
  logic             ph_release_cs;
  logic             cmd_ready;
  logic             ph_run;
  logic             halted;
  logic [CNT_W-1:0] steps_left;
  logic             brk_flag;
  logic [CYC_W-1:0] cycle_cnt;

  always #5 clk = ~clk;

  // Phaser stand-in: samples run at each 6-clk boundary; one release pulse
  // per CPU cycle executed, seen 6 clk before the next run sample.
  logic [2:0] ph_phase;
  logic       ph_active;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ph_phase  <= 3'd0;
      ph_active <= 1'b0;
    end else begin
      ph_phase <= (ph_phase == 3'd5) ? 3'd0 : ph_phase + 3'd1;
      if (ph_phase == 3'd5) ph_active <= ph_run;
    end
  end
  assign ph_release_cs = ph_active && (ph_phase == 3'd0);
  assign ph_stopped    = !ph_active;

  cpu_run_ctrl #(.CNT_W(CNT_W), .CYC_W(CYC_W), .BRK_EN(1'b1)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_count     (cmd_count),
    .brk_hit       (brk_hit),
    .ph_stopped    (ph_stopped),
    .ph_release_cs (ph_release_cs),
    .ph_run        (ph_run),
    .halted        (halted),
    .steps_left    (steps_left),
    .brk_flag      (brk_flag),
    .cycle_cnt     (cycle_cnt)
  );

  int               checks = 0;
  int               errors = 0;
  int               pulses = 0;
  int               m_mode;
  logic [CNT_W-1:0] m_steps;
  logic             m_brk;
  logic             m_run;
  logic [CYC_W-1:0] m_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_steps = '0;
    m_brk   = 1'b0;
    m_run   = 1'b0;
    m_cyc   = '0;
  endtask

  // Advance the model by one clock using the inputs about to be sampled
  task automatic model_step();
    logic             rel, brk, acc, next_run;
    logic [CNT_W-1:0] s;
    if (!resetn) begin
      model_reset();
      return;
    end
    rel      = ph_release_cs;
    brk      = rel && brk_hit;
    acc      = cmd_valid && (m_mode != M_DRAIN);
    next_run = (m_mode == M_FREE) || (m_mode == M_COUNT);
    if (rel) begin
      m_cyc = m_cyc + 1;
      pulses++;
    end
    case (m_mode)
      M_IDLE: begin
        if (acc && cmd_op == C_RUN) begin
          m_mode = M_FREE; m_brk = 1'b0;
        end else if (acc && cmd_op == C_STEP && cmd_count > 0) begin
          m_mode = M_COUNT; m_steps = cmd_count; m_brk = 1'b0;
        end
      end
      M_FREE: begin
        if (brk) begin
          m_mode = M_DRAIN; m_brk = 1'b1;
        end else if (acc && cmd_op == C_STOP) begin
          m_mode = M_DRAIN;
        end else if (acc && cmd_op == C_STEP) begin
          m_steps = cmd_count;
          m_mode  = (cmd_count > 0) ? M_COUNT : M_DRAIN;
        end
      end
      M_COUNT: begin
        s = m_steps;
        if (rel && s > 0) s = s - 1;
        if (brk) begin
          m_mode = M_DRAIN; m_brk = 1'b1; m_steps = s;
        end else if (acc && cmd_op == C_STEP) begin
          m_steps = cmd_count;
          m_mode  = (cmd_count > 0) ? M_COUNT : M_DRAIN;
        end else if (acc && cmd_op == C_RUN) begin
          m_mode = M_FREE; m_steps = '0;
        end else begin
          m_steps = s;
          if ((acc && cmd_op == C_STOP) || (rel && s == 0)) m_mode = M_DRAIN;
        end
      end
      default: begin
        if (ph_stopped) m_mode = M_IDLE;
      end
    endcase
    m_run = next_run;
  endtask

  task automatic compare();
    check("ph_run", ph_run, m_run);
    check("halted", halted, (m_mode == M_IDLE) && ph_stopped);
    check("cmd_ready", cmd_ready, m_mode != M_DRAIN);
    check("steps_left", steps_left, m_steps);
    check("brk_flag", brk_flag, m_brk);
    check("cycle_cnt", cycle_cnt, m_cyc);
  endtask

  // One clock: model update, edge, then compare on the falling edge
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic send_cmd(input logic [1:0] op, input int n);
    int k = 0;
    while (m_mode == M_DRAIN && k < 100) begin
      cycle();
      k++;
    end
    if (k >= 100) check("ready_timeout", 64'd0, 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = CNT_W'(n);
    cycle();
    cmd_valid = 1'b0;
    cmd_op    = C_NOP;
  endtask

  task automatic wait_halt(input string name, input int limit);
    int k = 0;
    while (!halted && k < limit) begin
      cycle();
      k++;
    end
    check({name, "_halt"}, halted, 1'b1);
  endtask

  initial begin
    logic [CNT_W-1:0] tr[$];
    logic [CYC_W-1:0] c0;
    int               k;
    bit               hit;

    // Reset, then idle with no commands
    model_reset();
    repeat (3) @(negedge clk);
    compare();
    resetn = 1'b1;
    repeat (20) cycle();
    check("idle_ph_run", ph_run, 1'b0);
    check("idle_halted", halted, 1'b1);
    check("idle_cycle_cnt", cycle_cnt, 64'd0);
    check("idle_ready", cmd_ready, 1'b1);

    // RUN for ~50 clk then STOP
    pulses = 0;
    send_cmd(C_RUN, 0);
    cycle();
    check("run_ph_run", ph_run, 1'b1);
    repeat (48) cycle();
    send_cmd(C_STOP, 0);
    check("stopping_ready", cmd_ready, 1'b0);
    wait_halt("run", 40);
    check("run_cyc_eq_pulses", cycle_cnt, 64'(pulses));
    check("run_pulses_range", (pulses >= 7) && (pulses <= 10), 1'b1);

    // STEP 3 from STOPPED
    c0 = cycle_cnt;
    pulses = 0;
    send_cmd(C_STEP, 3);
    tr.push_back(steps_left);
    k = 0;
    while (!halted && k < 120) begin
      cycle();
      if (steps_left != tr[$]) tr.push_back(steps_left);
      k++;
    end
    check("step3_halt", halted, 1'b1);
    check("step3_trace_len", 64'(tr.size()), 64'd4);
    for (int i = 0; i < 4 && i < tr.size(); i++) check("step3_trace", tr[i], 64'(3 - i));
    check("step3_pulses", 64'(pulses), 64'd3);
    check("step3_cyc", cycle_cnt, 64'(c0 + 3));
    check("step3_brk", brk_flag, 1'b0);

    // STEP 0 from STOPPED does nothing
    send_cmd(C_STEP, 0);
    cycle();
    check("step0_halted", halted, 1'b1);
    check("step0_ph_run", ph_run, 1'b0);

    // RUN with breakpoint on the 5th release
    pulses = 0;
    send_cmd(C_RUN, 0);
    k = 0;
    while (!halted && k < 300) begin
      brk_hit = ph_release_cs && (pulses == 4);
      cycle();
      k++;
    end
    brk_hit = 1'b0;
    check("brk_halt", halted, 1'b1);
    check("brk_flag_set", brk_flag, 1'b1);
    check("brk_pulses", 64'(pulses), 64'd5);

    // STEP 1 clears the breakpoint flag and runs one cycle
    pulses = 0;
    send_cmd(C_STEP, 1);
    check("step1_brk_clr", brk_flag, 1'b0);
    wait_halt("step1", 60);
    check("step1_pulses", 64'(pulses), 64'd1);

    // STEP 10 with STOP on the same clk as the 4th release
    pulses = 0;
    send_cmd(C_STEP, 10);
    k = 0;
    hit = 1'b0;
    while (!hit && k < 200) begin
      if (ph_release_cs && pulses == 3) begin
        cmd_valid = 1'b1;
        cmd_op    = C_STOP;
        hit       = 1'b1;
      end
      cycle();
      cmd_valid = 1'b0;
      cmd_op    = C_NOP;
      k++;
    end
    check("stop4_seen", hit, 1'b1);
    check("stop4_steps", steps_left, 64'd6);
    check("stop4_ready", cmd_ready, 1'b0);
    wait_halt("stop4", 40);
    check("stop4_steps_hold", steps_left, 64'd6);
    check("stop4_pulses", 64'(pulses), 64'd4);

    // STEP 100 aborted by an asynchronous reset
    send_cmd(C_STEP, 100);
    repeat (20) cycle();
    #2 resetn = 1'b0;
    #1;
    check("areset_ph_run", ph_run, 1'b0);
    check("areset_steps", steps_left, 64'd0);
    check("areset_cyc", cycle_cnt, 64'd0);
    model_reset();
    repeat (2) cycle();
    resetn = 1'b1;
    repeat (3) cycle();
    check("areset_halted", halted, 1'b1);

    // Randomized commands and breakpoints against the model
    for (int i = 0; i < 600; i++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_count = CNT_W'($urandom_range(0, 4));
      brk_hit   = ($urandom_range(0, 9) == 0);
      cycle();
    end
    cmd_valid = 1'b0;
    brk_hit   = 1'b0;
    repeat (20) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cpu_run_ctrl
`default_nettype wire
